// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions that collects
// out-of-order results from the CDB and retires them to commit in program order.
module rob #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 64,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int EXC_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [31:0]      issue_instr_i,
  input  logic [XLEN-1:0]  issue_pc_i,
  input  logic [4:0]       issue_rd_idx_i,
  input  logic             issue_res_ready_i,
  input  logic             issue_except_raised_i,
  input  logic [EXC_W-1:0] issue_except_code_i,
  output logic [IDX_W-1:0] issue_tail_idx_o,
  input  logic             cdb_valid_i,
  input  logic [IDX_W-1:0] cdb_idx_i,
  input  logic [XLEN-1:0]  cdb_value_i,
  input  logic             cdb_except_raised_i,
  input  logic [EXC_W-1:0] cdb_except_code_i,
  input  logic [IDX_W-1:0] opq_idx_i,
  output logic             opq_ready_o,
  output logic [XLEN-1:0]  opq_value_o,
  output logic             comm_valid_o,
  input  logic             comm_ready_i,
  output logic [31:0]      comm_instr_o,
  output logic [XLEN-1:0]  comm_pc_o,
  output logic [4:0]       comm_rd_idx_o,
  output logic [XLEN-1:0]  comm_value_o,
  output logic             comm_except_raised_o,
  output logic [EXC_W-1:0] comm_except_code_o,
  output logic [IDX_W-1:0] comm_head_idx_o
);

  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] rdy_q;
  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] tail_q;
  logic [IDX_W:0]   count_q;

  logic [31:0]      instr_q [DEPTH];
  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [4:0]       rd_q    [DEPTH];
  logic [XLEN-1:0]  value_q [DEPTH];
  logic             exc_q   [DEPTH];
  logic [EXC_W-1:0] code_q  [DEPTH];

  logic push;
  logic pop;
  logic cdb_wr;

  // Full is judged from the registered count only, so a same-cycle pop never frees a slot.
  assign issue_ready_o    = (count_q != CNT_FULL);
  assign issue_tail_idx_o = tail_q;
  assign push             = issue_valid_i & issue_ready_o;
  assign comm_valid_o     = valid_q[head_q] & rdy_q[head_q];
  assign pop              = comm_valid_o & comm_ready_i;
  assign cdb_wr           = cdb_valid_i & valid_q[cdb_idx_i];

  assign comm_instr_o         = instr_q[head_q];
  assign comm_pc_o            = pc_q[head_q];
  assign comm_rd_idx_o        = rd_q[head_q];
  assign comm_value_o         = value_q[head_q];
  assign comm_except_raised_o = exc_q[head_q];
  assign comm_except_code_o   = code_q[head_q];
  assign comm_head_idx_o      = head_q;

  assign opq_ready_o = valid_q[opq_idx_i] & rdy_q[opq_idx_i];
  assign opq_value_o = value_q[opq_idx_i];

  // Control state: occupancy flags and queue pointers
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_q <= '0;
      rdy_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (cdb_wr) rdy_q[cdb_idx_i] <= 1'b1;
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_ONE;
      end
      // Push is ordered after CDB so its fields win on an index collision.
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        rdy_q[tail_q]   <= issue_res_ready_i | issue_except_raised_i;
        tail_q          <= tail_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage: never reset, qualified by valid_q
  always_ff @(posedge clk_i) begin
    if (cdb_wr) begin
      value_q[cdb_idx_i] <= cdb_value_i;
      exc_q[cdb_idx_i]   <= cdb_except_raised_i;
      code_q[cdb_idx_i]  <= cdb_except_code_i;
    end
    if (push) begin
      instr_q[tail_q] <= issue_instr_i;
      pc_q[tail_q]    <= issue_pc_i;
      rd_q[tail_q]    <= issue_rd_idx_i;
      value_q[tail_q] <= '0;
      exc_q[tail_q]   <= issue_except_raised_i;
      code_q[tail_q]  <= issue_except_code_i;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: fill/wrap, CDB completion, in-order commit,
// exception forwarding, flush priority and reset.
module tb_rob;

  localparam int DEPTH = 8;
  localparam int XLEN  = 64;
  localparam int IDX_W = 3;
  localparam int EXC_W = 6;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             issue_valid;
  logic             issue_ready;
  logic [31:0]      issue_instr;
  logic [XLEN-1:0]  issue_pc;
  logic [4:0]       issue_rd_idx;
  logic             issue_res_ready;
  logic             issue_exc;
  logic [EXC_W-1:0] issue_code;
  logic [IDX_W-1:0] tail_idx;
  logic             cdb_valid;
  logic [IDX_W-1:0] cdb_idx;
  logic [XLEN-1:0]  cdb_value;
  logic             cdb_exc;
  logic [EXC_W-1:0] cdb_code;
  logic [IDX_W-1:0] opq_idx;
  logic             opq_ready;
  logic [XLEN-1:0]  opq_value;
  logic             comm_valid;
  logic             comm_ready;
  logic [31:0]      comm_instr;
  logic [XLEN-1:0]  comm_pc;
  logic [4:0]       comm_rd_idx;
  logic [XLEN-1:0]  comm_value;
  logic             comm_exc;
  logic [EXC_W-1:0] comm_code;
  logic [IDX_W-1:0] head_idx;

  int n_cmp = 0;
  int n_bad = 0;

  rob #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_instr_i(issue_instr), .issue_pc_i(issue_pc),
    .issue_rd_idx_i(issue_rd_idx), .issue_res_ready_i(issue_res_ready),
    .issue_except_raised_i(issue_exc), .issue_except_code_i(issue_code),
    .issue_tail_idx_o(tail_idx),
    .cdb_valid_i(cdb_valid), .cdb_idx_i(cdb_idx), .cdb_value_i(cdb_value),
    .cdb_except_raised_i(cdb_exc), .cdb_except_code_i(cdb_code),
    .opq_idx_i(opq_idx), .opq_ready_o(opq_ready), .opq_value_o(opq_value),
    .comm_valid_o(comm_valid), .comm_ready_i(comm_ready),
    .comm_instr_o(comm_instr), .comm_pc_o(comm_pc), .comm_rd_idx_o(comm_rd_idx),
    .comm_value_o(comm_value), .comm_except_raised_o(comm_exc),
    .comm_except_code_o(comm_code), .comm_head_idx_o(head_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; issue_valid = 0; issue_res_ready = 0; issue_exc = 0; issue_code = '0;
    cdb_valid = 0; cdb_exc = 0; cdb_code = '0; comm_ready = 0;
  endtask

  task automatic set_issue(input logic [31:0] ins, input logic [63:0] pc, input logic [4:0] rd,
                           input logic rr, input logic ex, input logic [5:0] code);
    issue_valid = 1; issue_instr = ins; issue_pc = pc; issue_rd_idx = rd;
    issue_res_ready = rr; issue_exc = ex; issue_code = code;
  endtask

  task automatic set_cdb(input logic [2:0] idx, input logic [63:0] val,
                         input logic ex, input logic [5:0] code);
    cdb_valid = 1; cdb_idx = idx; cdb_value = val; cdb_exc = ex; cdb_code = code;
  endtask

  initial begin
    idle();
    rst = 1; issue_instr = '0; issue_pc = '0; issue_rd_idx = '0;
    cdb_idx = '0; cdb_value = '0; opq_idx = '0;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_comm_valid",  64'(comm_valid),  64'd0);
    chk("rst_tail",        64'(tail_idx),    64'd0);
    chk("rst_head",        64'(head_idx),    64'd0);
    chk("rst_opq_ready",   64'(opq_ready),   64'd0);

    // Fill all eight entries with pending results; commit side eager.
    comm_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_tail", 64'(tail_idx), 64'(i));
      chk("fill_ready_before", 64'(issue_ready), 64'd1);
      set_issue(32'h13 + 32'(i), 64'h100 + 64'(4*i), 5'(i+1), 0, 0, '0);
      tick();
    end
    idle();
    #1;
    chk("full_issue_ready", 64'(issue_ready), 64'd0);
    chk("full_comm_valid",  64'(comm_valid),  64'd0);
    chk("full_tail_wrap",   64'(tail_idx),    64'd0);

    // Complete entry 0; result must not be bypassed in the same cycle.
    set_cdb(3'd0, 64'hAB, 0, '0);
    #1;
    chk("cdb_no_bypass", 64'(comm_valid), 64'd0);
    tick();
    idle();
    opq_idx = 3'd0;
    #1;
    chk("cdb_comm_valid", 64'(comm_valid),  64'd1);
    chk("cdb_comm_value", comm_value,       64'hAB);
    chk("cdb_comm_pc",    comm_pc,          64'h100);
    chk("cdb_comm_instr", 64'(comm_instr),  64'h13);
    chk("cdb_comm_rd",    64'(comm_rd_idx), 64'd1);
    chk("opq0_ready",     64'(opq_ready),   64'd1);
    chk("opq0_value",     opq_value,        64'hAB);

    // Pop while full with an issue attempt: the push must not slip in.
    comm_ready = 1;
    set_issue(32'hDEAD, 64'h999, 5'd9, 1, 0, '0);
    tick();
    idle();
    #1;
    chk("pop_head",        64'(head_idx),    64'd1);
    chk("pop_issue_ready", 64'(issue_ready), 64'd1);
    chk("pop_no_push",     64'(tail_idx),    64'd0);
    chk("pop_next_valid",  64'(comm_valid),  64'd0);

    // Flush a 7-entry queue.
    flush = 1;
    tick();
    idle();
    #1;
    chk("flush7_head",  64'(head_idx),    64'd0);
    chk("flush7_tail",  64'(tail_idx),    64'd0);
    chk("flush7_valid", 64'(comm_valid),  64'd0);
    chk("flush7_ready", 64'(issue_ready), 64'd1);

    // Three pending entries completed out of order 2,1,0 commit in order 0,1,2.
    for (int i = 0; i < 3; i++) begin
      set_issue(32'h200 + 32'(i), 64'h2000 + 64'(i), 5'(i+10), 0, 0, '0);
      tick();
    end
    idle();
    set_cdb(3'd2, 64'h22, 0, '0); tick();
    idle(); #1;
    chk("ooo_after2_valid", 64'(comm_valid), 64'd0);
    set_cdb(3'd1, 64'h11, 0, '0); tick();
    idle(); #1;
    chk("ooo_after1_valid", 64'(comm_valid), 64'd0);
    set_cdb(3'd0, 64'h10, 0, '0); tick();
    idle(); #1;
    chk("ooo_c0_valid", 64'(comm_valid), 64'd1);
    chk("ooo_c0_value", comm_value,      64'h10);
    chk("ooo_c0_head",  64'(head_idx),   64'd0);
    comm_ready = 1;
    tick();
    chk("ooo_c1_valid", 64'(comm_valid), 64'd1);
    chk("ooo_c1_value", comm_value,      64'h11);
    chk("ooo_c1_pc",    comm_pc,         64'h2001);
    tick();
    chk("ooo_c2_valid", 64'(comm_valid), 64'd1);
    chk("ooo_c2_value", comm_value,      64'h22);
    chk("ooo_c2_rd",    64'(comm_rd_idx), 64'd12);
    tick();
    idle(); #1;
    chk("ooo_empty_valid", 64'(comm_valid), 64'd0);
    chk("ooo_empty_head",  64'(head_idx),   64'd3);

    // Issue-time exception commits one cycle later with its code.
    set_issue(32'h300, 64'h3000, 5'd3, 0, 1, 6'd2);
    tick();
    idle(); #1;
    chk("exc_valid", 64'(comm_valid), 64'd1);
    chk("exc_raised", 64'(comm_exc),  64'd1);
    chk("exc_code",  64'(comm_code),  64'd2);
    chk("exc_head",  64'(head_idx),   64'd3);
    chk("exc_value", comm_value,      64'd0);
    comm_ready = 1; tick(); idle();

    // Execution exception via CDB overrides stored exception fields.
    set_issue(32'h400, 64'h4000, 5'd4, 0, 0, '0);
    tick(); idle();
    set_cdb(3'd4, 64'h55, 1, 6'd5);
    tick(); idle(); #1;
    chk("cdbexc_valid", 64'(comm_valid), 64'd1);
    chk("cdbexc_raised", 64'(comm_exc),  64'd1);
    chk("cdbexc_code",  64'(comm_code),  64'd5);
    chk("cdbexc_value", comm_value,      64'h55);
    comm_ready = 1; tick(); idle();

    // CDB to an unallocated slot is ignored.
    set_cdb(3'd5, 64'hFF, 0, '0);
    tick(); idle();
    opq_idx = 3'd5;
    #1;
    chk("inv_opq_ready", 64'(opq_ready),   64'd0);
    chk("inv_comm_valid", 64'(comm_valid), 64'd0);
    chk("inv_head",      64'(head_idx),    64'd5);
    chk("inv_tail",      64'(tail_idx),    64'd5);
    chk("inv_issue_rdy", 64'(issue_ready), 64'd1);

    // Build count=3 with a ready head, then push+pop+flush in one cycle.
    for (int i = 0; i < 3; i++) begin
      set_issue(32'h500 + 32'(i), 64'h5000 + 64'(i), 5'(i+20), 1, 0, '0);
      tick();
    end
    idle(); #1;
    chk("pre_flush_valid", 64'(comm_valid), 64'd1);
    chk("pre_flush_tail",  64'(tail_idx),   64'd0);
    chk("opq5_ready",      64'(opq_ready),  64'd1);
    flush = 1; comm_ready = 1;
    set_issue(32'h600, 64'h6000, 5'd6, 1, 0, '0);
    tick();
    idle(); #1;
    chk("fpp_head",  64'(head_idx),    64'd0);
    chk("fpp_tail",  64'(tail_idx),    64'd0);
    chk("fpp_valid", 64'(comm_valid),  64'd0);
    chk("fpp_ready", 64'(issue_ready), 64'd1);
    // Occupancy really is zero: exactly eight pushes fill it.
    for (int i = 0; i < DEPTH; i++) begin
      chk("fpp_fill_ready", 64'(issue_ready), 64'd1);
      set_issue(32'h700, 64'h7000, 5'd7, 0, 0, '0);
      tick();
    end
    idle(); #1;
    chk("fpp_full", 64'(issue_ready), 64'd0);

    // Reset mid-operation discards everything.
    rst = 1;
    tick();
    rst = 0; #1;
    chk("mid_rst_ready", 64'(issue_ready), 64'd1);
    chk("mid_rst_valid", 64'(comm_valid),  64'd0);
    chk("mid_rst_tail",  64'(tail_idx),    64'd0);
    chk("mid_rst_head",  64'(head_idx),    64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning number of entries (power of two, >=2).
REQ-002 The block SHALL have parameter XLEN, default 64, meaning data/PC width; IDX_W = log2(DEPTH), EXC_W = 6 (except code width).
REQ-003 The block SHALL have ports (name dir width meaning):
 clk_i in 1 clock, rising edge;
 rst_i in 1 reset, synchronous, active-high;
 flush_i in 1 synchronous flush of all entries;
 issue_valid_i in 1 issue-side entry request;
 issue_ready_o out 1 free entry available;
 issue_instr_i in 32 instruction word;
 issue_pc_i in XLEN instruction PC;
 issue_rd_idx_i in 5 destination register index;
 issue_res_ready_i in 1 result already complete at issue (no execution needed);
 issue_except_raised_i in 1 exception detected at issue;
 issue_except_code_i in EXC_W issue exception code;
 issue_tail_idx_o out IDX_W index allocated to the issuing instruction;
 cdb_valid_i in 1 result broadcast valid;
 cdb_idx_i in IDX_W target entry;
 cdb_value_i in XLEN result value;
 cdb_except_raised_i in 1 execution exception;
 cdb_except_code_i in EXC_W execution exception code;
 opq_idx_i in IDX_W operand query entry index;
 opq_ready_o out 1 queried entry holds a completed result;
 opq_value_o out XLEN queried entry value;
 comm_valid_o out 1 head entry ready to commit;
 comm_ready_i in 1 commit stage pops head;
 comm_instr_o out 32, comm_pc_o out XLEN, comm_rd_idx_o out 5, comm_value_o out XLEN, comm_except_raised_o out 1, comm_except_code_o out EXC_W: head entry fields;
 comm_head_idx_o out IDX_W head index.

Function
REQ-004 Each entry SHALL store valid, res_ready, instr, pc, rd_idx, value, except_raised, except_code.
REQ-005 head, tail (IDX_W) and count (IDX_W+1) registers SHALL implement a circular FIFO; pointers wrap DEPTH-1 -> 0.
REQ-006 issue_ready_o SHALL equal (count != DEPTH), from registered state only; no combinational path from comm_ready_i.
REQ-007 Push occurs when issue_valid_i & issue_ready_o: entry[tail] written with valid=1, res_ready=issue_res_ready_i | issue_except_raised_i, value=0, issue fields; tail+=1.
REQ-008 issue_tail_idx_o SHALL equal tail (combinational from register).
REQ-009 comm_valid_o SHALL equal entry[head].valid & entry[head].res_ready; comm_* fields driven from entry[head] regardless of valid.
REQ-010 Pop occurs when comm_valid_o & comm_ready_i: entry[head].valid cleared, head+=1.
REQ-011 count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or neither.
REQ-012 When full, a same-cycle pop SHALL NOT enable a push that cycle.
REQ-013 CDB write when cdb_valid_i & entry[cdb_idx_i].valid: value, except_raised, except_code overwritten, res_ready set; CDB to an invalid entry ignored.
REQ-014 CDB write and push to same index in one cycle SHALL NOT occur (index not allocated); push fields take priority if it does.
REQ-015 CDB result SHALL be visible on comm_*/opq_* one cycle after cdb_valid_i (no bypass); minimum issue-to-commit latency 1 cycle (res_ready at issue).
REQ-016 opq_ready_o SHALL equal entry[opq_idx_i].valid & res_ready; opq_value_o = entry[opq_idx_i].value; combinational, no CDB bypass.
REQ-017 flush_i SHALL clear all valid bits and set head=tail=count=0 on the next edge, overriding push, pop and CDB in the same cycle.
REQ-018 The block SHALL not check or interpret instruction opcodes; exceptions are forwarded, not handled.

Reset
REQ-019 On rst_i high at a clock edge: all valid and res_ready=0, head=tail=count=0; data fields need not be reset.
REQ-020 After reset: issue_ready_o=1, comm_valid_o=0, issue_tail_idx_o=0, comm_head_idx_o=0, opq_ready_o=0; reset mid-operation discards all entries, same as flush.

Verification
REQ-021 Push 8 entries (res_ready=0), comm_ready_i=1 -> issue_ready_o=0 after 8th push, count=8, comm_valid_o=0, issue_tail_idx_o=0 (wrapped).
REQ-022 Full ROB, CDB idx 0 value 0xAB -> next cycle comm_valid_o=1, comm_value_o=0xAB; pop -> issue_ready_o=1 following cycle, head=1.
REQ-023 CDB to entries 2 then 1 then 0 out of order -> commits in order 0,1,2, one per cycle with comm_ready_i=1.
REQ-024 Entry issued with issue_except_raised_i=1, code 2 -> comm_valid_o=1 next cycle at head, comm_except_raised_o=1, comm_except_code_o=2.
REQ-025 count=3, same cycle push + pop + flush_i -> next cycle count=0, head=tail=0, comm_valid_o=0, issue_ready_o=1.
REQ-026 CDB to an invalid index 5 with empty ROB -> opq_idx_i=5 yields opq_ready_o=0, no state change.
